dbg_bus_arbiter: RTL and testbench

DBG_BUS_ARBITER -- requirements
Module: dbg_bus_arbiter

---
 rtl/dbg_bus_pkg.sv | 18 +
 rtl/dbg_req_slot.sv | 56 +++++
 rtl/dbg_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_dbg_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug/CPU target bus arbiter.
package dbg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_e;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
    localparam int          TO_CNT_W    = 8;

endpackage

// File: rtl/dbg_req_slot.sv
// Single-entry debug request slot: captures strobes, flags dropped ones,
// and presents a request view that includes a strobe arriving this cycle.
module dbg_req_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic        clr,
    output logic        pending,
    output logic        overrun,
    output logic        req_valid,
    output logic        req_we,
    output logic [2:0]  req_addr,
    output logic [31:0] req_wdata
);

    logic        strobe;
    logic        accept;
    logic        slot_we;
    logic [2:0]  slot_addr;
    logic [31:0] slot_wdata;

    assign strobe = rd | wr;
    // A strobe landing on the clearing cycle refills the slot instead of overrunning.
    assign accept = strobe & (~pending | clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            overrun    <= 1'b0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else begin
            if (accept) begin
                pending    <= 1'b1;
                slot_we    <= wr;
                slot_addr  <= addr;
                slot_wdata <= wdata;
            end else if (clr) begin
                pending <= 1'b0;
            end
            if (strobe && pending && !clr) begin
                overrun <= 1'b1;
            end
        end
    end

    assign req_valid = pending | accept;
    assign req_we    = pending ? slot_we    : wr;
    assign req_addr  = pending ? slot_addr  : addr;
    assign req_wdata = pending ? slot_wdata : wdata;

endmodule

// File: rtl/dbg_bus_arbiter.sv
// Arbitrates a debug request slot and a CPU port onto one shared target bus,
// with round-robin tie-break and a per-transaction timeout.
module dbg_bus_arbiter
    import dbg_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_rd,
    input  logic        dbg_wr,
    input  logic [2:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_pending,
    output logic        dbg_err,
    output logic        dbg_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        t_req,
    output logic        t_we,
    output logic [2:0]  t_addr,
    output logic [31:0] t_wdata,
    input  logic        t_ack,
    input  logic [31:0] t_rdata,
    output state_e      fsm_state
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state;
    grant_e              grant;
    grant_e              last_grant;
    logic [TO_CNT_W-1:0] to_cnt;

    logic        slot_clr;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;

    logic        pick_dbg;
    logic        bus_end;
    logic        timed_out;
    logic [31:0] done_data;

    assign slot_clr = (state == ST_DONE) && (grant == GNT_DBG);

    dbg_req_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (dbg_rd),
        .wr        (dbg_wr),
        .addr      (dbg_addr),
        .wdata     (dbg_wdata),
        .clr       (slot_clr),
        .pending   (dbg_pending),
        .overrun   (dbg_overrun),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata)
    );

    // On a tie, the requester that did not win last time gets the bus.
    always_comb begin
        pick_dbg = req_valid;
        if (req_valid && cpu_req) begin
            pick_dbg = (last_grant == GNT_CPU);
        end
    end

    always_comb begin
        bus_end   = t_ack || (to_cnt == TO_LAST);
        timed_out = !t_ack;
        if (t_we) begin
            done_data = '0;
        end else if (t_ack) begin
            done_data = t_rdata;
        end else begin
            done_data = ERR_PATTERN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= GNT_CPU;
            last_grant <= GNT_CPU;
            to_cnt     <= '0;
            t_req      <= 1'b0;
            t_we       <= 1'b0;
            t_addr     <= '0;
            t_wdata    <= '0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req || req_valid) begin
                        state      <= ST_BUS;
                        grant      <= pick_dbg ? GNT_DBG : GNT_CPU;
                        last_grant <= pick_dbg ? GNT_DBG : GNT_CPU;
                        to_cnt     <= '0;
                        t_req      <= 1'b1;
                        t_we       <= pick_dbg ? req_we    : cpu_we;
                        t_addr     <= pick_dbg ? req_addr  : cpu_addr;
                        t_wdata    <= pick_dbg ? req_wdata : cpu_wdata;
                    end
                end
                ST_BUS: begin
                    if (bus_end) begin
                        state <= ST_DONE;
                        t_req <= 1'b0;
                        if (grant == GNT_CPU) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= done_data;
                            cpu_err   <= timed_out;
                        end else begin
                            dbg_err <= timed_out;
                            if (!t_we) begin
                                dbg_rdata <= done_data;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed bench for dbg_bus_arbiter with TIMEOUT_CYCLES = 4.
module tb_dbg_bus_arbiter;
    import dbg_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbg_rd = 1'b0;
    logic        dbg_wr = 1'b0;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_pending;
    logic        dbg_err;
    logic        dbg_overrun;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        t_req;
    logic        t_we;
    logic [2:0]  t_addr;
    logic [31:0] t_wdata;
    logic        t_ack = 1'b0;
    logic [31:0] t_rdata = '0;
    state_e      fsm_state;

    int checks = 0;
    int errors = 0;

    dbg_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dbg_rd      (dbg_rd),
        .dbg_wr      (dbg_wr),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .dbg_pending (dbg_pending),
        .dbg_err     (dbg_err),
        .dbg_overrun (dbg_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .t_req       (t_req),
        .t_we        (t_we),
        .t_addr      (t_addr),
        .t_wdata     (t_wdata),
        .t_ack       (t_ack),
        .t_rdata     (t_rdata),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        dbg_rd  = 1'b0;
        dbg_wr  = 1'b0;
        cpu_req = 1'b0;
        t_ack   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        logic [31:0] wd;
        int          req_cycles;
        bit          acked;

        // Reset state
        step();
        step();
        check("rst_t_req", 32'(t_req), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_pending", 32'(dbg_pending), 32'd0);
        check("rst_overrun", 32'(dbg_overrun), 32'd0);
        check("rst_dbg_err", 32'(dbg_err), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_t_wdata", t_wdata, 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        // t_ack outside BUS is ignored
        t_ack = 1'b1;
        step();
        t_ack = 1'b0;
        check("idle_ack_state", 32'(fsm_state), 32'(ST_IDLE));
        check("idle_ack_cpu_ack", 32'(cpu_ack), 32'd0);

        // Debug write, ack two cycles after t_req
        dbg_wr = 1'b1; dbg_addr = 3'd3; dbg_wdata = 32'h1234_5678;
        step();
        dbg_wr = 1'b0;
        check("w_pending", 32'(dbg_pending), 32'd1);
        check("w_t_req", 32'(t_req), 32'd1);
        check("w_t_we", 32'(t_we), 32'd1);
        check("w_t_addr", 32'(t_addr), 32'd3);
        check("w_t_wdata", t_wdata, 32'h1234_5678);
        step();
        check("w_t_req_hold", 32'(t_req), 32'd1);
        t_ack = 1'b1; t_rdata = 32'hAAAA_5555;
        step();
        t_ack = 1'b0;
        check("w_done_state", 32'(fsm_state), 32'(ST_DONE));
        check("w_t_req_drop", 32'(t_req), 32'd0);
        check("w_dbg_err", 32'(dbg_err), 32'd0);
        check("w_dbg_rdata", dbg_rdata, 32'd0);
        step();
        check("w_pending_clr", 32'(dbg_pending), 32'd0);

        // Simultaneous requests after reset: debug first, then CPU
        do_reset();
        rd_a = $urandom;
        rd_b = $urandom;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
        dbg_rd = 1'b1; dbg_addr = 3'd2;
        step();
        dbg_rd = 1'b0;
        check("tie_t_addr_dbg", 32'(t_addr), 32'd2);
        check("tie_t_we_dbg", 32'(t_we), 32'd0);
        t_ack = 1'b1; t_rdata = rd_a;
        step();
        t_ack = 1'b0;
        check("tie_dbg_rdata", dbg_rdata, rd_a);
        check("tie_no_cpu_ack", 32'(cpu_ack), 32'd0);
        step();
        check("tie_pending_clr", 32'(dbg_pending), 32'd0);
        step();
        check("tie_t_addr_cpu", 32'(t_addr), 32'd1);
        check("tie_t_req_cpu", 32'(t_req), 32'd1);
        t_ack = 1'b1; t_rdata = rd_b;
        step();
        t_ack = 1'b0;
        cpu_req = 1'b0;
        check("tie_cpu_ack", 32'(cpu_ack), 32'd1);
        check("tie_cpu_rdata", cpu_rdata, rd_b);
        check("tie_cpu_err", 32'(cpu_err), 32'd0);
        step();
        check("tie_cpu_ack_1cyc", 32'(cpu_ack), 32'd0);

        // CPU read timeout after 4 BUS cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd5;
        req_cycles = 0;
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_ack) begin
                acked = 1'b1;
                break;
            end
            if (t_req) req_cycles++;
        end
        cpu_req = 1'b0;
        check("to_acked", 32'(acked), 32'd1);
        check("to_t_req_cycles", 32'(req_cycles), 32'd4);
        check("to_cpu_err", 32'(cpu_err), 32'd1);
        check("to_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();
        check("to_ack_drop", 32'(cpu_ack), 32'd0);

        // Strobe in debug DONE is accepted; rd&wr together is a write
        rd_a = $urandom;
        wd = $urandom;
        dbg_rd = 1'b1; dbg_addr = 3'd7;
        step();
        dbg_rd = 1'b0;
        t_ack = 1'b1; t_rdata = rd_a;
        step();
        t_ack = 1'b0;
        check("dn_state", 32'(fsm_state), 32'(ST_DONE));
        check("dn_dbg_rdata", dbg_rdata, rd_a);
        dbg_rd = 1'b1; dbg_wr = 1'b1; dbg_addr = 3'd1; dbg_wdata = wd;
        step();
        dbg_rd = 1'b0; dbg_wr = 1'b0;
        check("dn_pending_refill", 32'(dbg_pending), 32'd1);
        check("dn_no_overrun", 32'(dbg_overrun), 32'd0);
        step();
        check("dn_t_req", 32'(t_req), 32'd1);
        check("dn_t_we", 32'(t_we), 32'd1);
        check("dn_t_addr", 32'(t_addr), 32'd1);
        check("dn_t_wdata", t_wdata, wd);
        t_ack = 1'b1; t_rdata = 32'h0BAD_F00D;
        step();
        t_ack = 1'b0;
        check("dn_rdata_kept", dbg_rdata, rd_a);
        step();

        // Second strobe while slot full -> sticky overrun
        rd_b = $urandom;
        dbg_rd = 1'b1; dbg_addr = 3'd4;
        step();
        dbg_addr = 3'd6;
        step();
        dbg_rd = 1'b0;
        check("ov_overrun", 32'(dbg_overrun), 32'd1);
        check("ov_t_addr", 32'(t_addr), 32'd4);
        t_ack = 1'b1; t_rdata = rd_b;
        step();
        t_ack = 1'b0;
        check("ov_dbg_rdata", dbg_rdata, rd_b);
        check("ov_dbg_err", 32'(dbg_err), 32'd0);
        step();
        check("ov_pending_clr", 32'(dbg_pending), 32'd0);
        step();
        check("ov_no_new_req", 32'(t_req), 32'd0);
        check("ov_sticky", 32'(dbg_overrun), 32'd1);

        // Asynchronous reset during BUS
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2;
        step();
        check("ar_t_req_before", 32'(t_req), 32'd1);
        #2;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("ar_t_req_async", 32'(t_req), 32'd0);
        check("ar_overrun_clr", 32'(dbg_overrun), 32'd0);
        step();
        check("ar_no_ack", 32'(cpu_ack), 32'd0);
        rst_n = 1'b1;
        step();
        check("ar_no_ack_after", 32'(cpu_ack), 32'd0);
        rd_a = $urandom;
        cpu_req = 1'b1; cpu_addr = 3'd3;
        step();
        check("ar_fresh_t_addr", 32'(t_addr), 32'd3);
        t_ack = 1'b1; t_rdata = rd_a;
        step();
        t_ack = 1'b0;
        cpu_req = 1'b0;
        check("ar_fresh_ack", 32'(cpu_ack), 32'd1);
        check("ar_fresh_rdata", cpu_rdata, rd_a);
        check("ar_fresh_err", 32'(cpu_err), 32'd0);
        step();

        // t_ack on the timeout cycle wins
        rd_b = $urandom;
        cpu_req = 1'b1; cpu_addr = 3'd6;
        step();
        step();
        step();
        step();
        check("tw_still_bus", 32'(t_req), 32'd1);
        t_ack = 1'b1; t_rdata = rd_b;
        step();
        t_ack = 1'b0;
        cpu_req = 1'b0;
        check("tw_ack", 32'(cpu_ack), 32'd1);
        check("tw_err", 32'(cpu_err), 32'd0);
        check("tw_rdata", cpu_rdata, rd_b);
        step();

        // CPU write returns zero read data
        wd = $urandom;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd6; cpu_wdata = wd;
        step();
        check("cw_t_we", 32'(t_we), 32'd1);
        check("cw_t_wdata", t_wdata, wd);
        t_ack = 1'b1; t_rdata = 32'hFFFF_FFFF;
        step();
        t_ack = 1'b0;
        cpu_req = 1'b0;
        check("cw_ack", 32'(cpu_ack), 32'd1);
        check("cw_rdata", cpu_rdata, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
